// File: rtl/dff_clkdiv_pipe_if.sv
// Data/valid in, divided clock plus aligned pipeline output back out.
// The block drives the slave side; a source or bench drives the master side.
interface dff_clkdiv_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                         hold;
    logic                         flush;
    logic [WIDTH-1:0]             d;
    logic                         d_valid;
    logic                         clkout;
    logic                         tick;
    logic [WIDTH-1:0]             q;
    logic                         q_valid;
    logic [$clog2(DEPTH+1)-1:0]   level;

    modport master (
        output hold, flush, d, d_valid,
        input  clkout, tick, q, q_valid, level
    );

    modport slave (
        input  hold, flush, d, d_valid,
        output clkout, tick, q, q_valid, level
    );
endinterface

// File: rtl/dff_clkdiv_pipe.sv
// Divides clk by 2*DIV onto clkout and advances a DEPTH-stage data/valid pipeline
// on every clkout rise, using the rise as a clock enable inside the clk domain.
module dff_clkdiv_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV   = 2
) (
    input logic              clk,
    input logic              reset,
    dff_clkdiv_pipe_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [CW-1:0]    cnt;
    logic             clkoutReg;
    logic [WIDTH-1:0] stageData [DEPTH];
    logic [DEPTH-1:0] stageValid;
    logic [DEPTH-1:0] nextValid;
    logic [LW-1:0]    levelReg;
    logic [LW-1:0]    nextLevel;
    logic             tick;

    assign tick = (cnt == CW'(DIV - 1)) & ~clkoutReg & ~bus.hold & ~reset;

    // Level is the popcount of the post-edge valid vector, so flush and bubbles need no special cases
    always_comb begin
        nextValid = stageValid;
        if (tick) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                nextValid[i] = stageValid[i-1];
            end
            nextValid[0] = bus.d_valid;
        end
        if (bus.flush) begin
            nextValid = '0;
        end
        nextLevel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nextLevel = nextLevel + LW'(nextValid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            clkoutReg  <= 1'b0;
            stageValid <= '0;
            levelReg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stageData[i] <= '0;
            end
        end else begin
            if (!bus.hold) begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt       <= '0;
                    clkoutReg <= ~clkoutReg;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            // Data shifts on every tick whether or not it is valid
            if (tick) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    stageData[i] <= stageData[i-1];
                end
                stageData[0] <= bus.d;
            end
            stageValid <= nextValid;
            levelReg   <= nextLevel;
        end
    end

    assign bus.clkout  = clkoutReg;
    assign bus.tick    = tick;
    assign bus.q       = stageData[DEPTH-1];
    assign bus.q_valid = stageValid[DEPTH-1];
    assign bus.level   = levelReg;
endmodule

// File: tb/tb_dff_clkdiv_pipe.sv
// Randomised and directed checks of three divider/depth configurations against
// a phase-count and sample-history model of the divided clock and pipeline.
module tb_dff_clkdiv_pipe;
    localparam int NI = 3;

    logic       clk;
    logic       reset;
    logic       hold;
    logic       flush;
    logic [7:0] d;
    logic       dValid;

    int divv   [NI] = '{2, 1, 3};
    int depthv [NI] = '{4, 1, 2};

    int checkCount = 0;
    int passCount  = 0;

    // Model: n counts un-held edges since reset; history holds the last samples taken on ticks
    int         n     [NI];
    logic [7:0] histD [NI][4];
    logic       histV [NI][4];

    logic [NI-1:0] tickObs;
    logic [NI-1:0] clkObs;
    logic [NI-1:0] qvObs;
    logic [7:0]    qObs   [NI];
    logic [3:0]    lvlObs [NI];

    logic [7:0] fillVals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int         fillLvl  [5] = '{1, 2, 3, 4, 4};
    int         firstRise [NI];

    dff_clkdiv_pipe_if #(.WIDTH(8), .DEPTH(4)) bus0 ();
    dff_clkdiv_pipe_if #(.WIDTH(8), .DEPTH(1)) bus1 ();
    dff_clkdiv_pipe_if #(.WIDTH(8), .DEPTH(2)) bus2 ();

    dff_clkdiv_pipe #(.WIDTH(8), .DEPTH(4), .DIV(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    dff_clkdiv_pipe #(.WIDTH(8), .DEPTH(1), .DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    dff_clkdiv_pipe #(.WIDTH(8), .DEPTH(2), .DIV(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    assign bus0.hold = hold;  assign bus0.flush = flush;  assign bus0.d = d;  assign bus0.d_valid = dValid;
    assign bus1.hold = hold;  assign bus1.flush = flush;  assign bus1.d = d;  assign bus1.d_valid = dValid;
    assign bus2.hold = hold;  assign bus2.flush = flush;  assign bus2.d = d;  assign bus2.d_valid = dValid;

    assign tickObs = {bus2.tick, bus1.tick, bus0.tick};
    assign clkObs  = {bus2.clkout, bus1.clkout, bus0.clkout};
    assign qvObs   = {bus2.q_valid, bus1.q_valid, bus0.q_valid};
    assign qObs[0] = bus0.q;
    assign qObs[1] = bus1.q;
    assign qObs[2] = bus2.q;
    assign lvlObs[0] = 4'(bus0.level);
    assign lvlObs[1] = 4'(bus1.level);
    assign lvlObs[2] = 4'(bus2.level);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic modelTick(int k);
        return !reset && !hold && ((n[k] % (2 * divv[k])) == divv[k] - 1);
    endfunction

    function automatic logic expClk(int k);
        return ((n[k] / divv[k]) % 2) == 1;
    endfunction

    function automatic int expLevel(int k);
        int s = 0;
        for (int j = 0; j < depthv[k]; j++) s += int'(histV[k][j]);
        return s;
    endfunction

    task automatic modelEdge();
        for (int k = 0; k < NI; k++) begin
            logic tk;
            tk = modelTick(k);
            if (reset) begin
                n[k] = 0;
                for (int j = 0; j < 4; j++) begin
                    histD[k][j] = 8'h00;
                    histV[k][j] = 1'b0;
                end
            end else begin
                if (!hold) n[k]++;
                if (tk) begin
                    for (int j = depthv[k] - 1; j > 0; j--) begin
                        histD[k][j] = histD[k][j-1];
                        histV[k][j] = histV[k][j-1];
                    end
                    histD[k][0] = d;
                    histV[k][0] = dValid;
                end
                if (flush) begin
                    for (int j = 0; j < 4; j++) histV[k][j] = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", tag, actual, expected, $time);
        else
            passCount++;
    endtask

    // One clk cycle: drive, check tick before the edge, advance model, check registered outputs
    task automatic applyStimulus(input logic r, input logic h, input logic f,
                                 input logic [7:0] dd, input logic dv);
        reset = r; hold = h; flush = f; d = dd; dValid = dv;
        #1;
        for (int k = 0; k < NI; k++)
            checkOutput($sformatf("tick_i%0d", k), 32'(tickObs[k]), 32'(modelTick(k)));
        @(posedge clk);
        modelEdge();
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("clkout_i%0d", k), 32'(clkObs[k]), 32'(expClk(k)));
            checkOutput($sformatf("q_i%0d", k), 32'(qObs[k]), 32'(histD[k][depthv[k]-1]));
            checkOutput($sformatf("q_valid_i%0d", k), 32'(qvObs[k]), 32'(histV[k][depthv[k]-1]));
            checkOutput($sformatf("level_i%0d", k), 32'(lvlObs[k]), 32'(expLevel(k)));
        end
    endtask

    // Idle until the DIV=2 instance is about to tick, then present the given sample on that cycle
    task automatic feedMainTick(input logic f, input logic [7:0] dd, input logic dv);
        int guard = 0;
        while ((n[0] % 4) != 1 && guard < 50) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
            guard++;
        end
        if (guard >= 50) checkOutput("tick_wait_timeout", 32'(guard), 32'd0);
        applyStimulus(1'b0, 1'b0, f, dd, dv);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) n[k] = 0;
        for (int k = 0; k < NI; k++)
            for (int j = 0; j < 4; j++) begin
                histD[k][j] = 8'h00;
                histV[k][j] = 1'b0;
            end

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
        checkOutput("reset_q", 32'(qObs[0]), 32'h0);
        checkOutput("reset_level", 32'(lvlObs[0]), 32'h0);

        for (int t = 0; t < 5; t++) begin
            feedMainTick(1'b0, fillVals[t], 1'b1);
            checkOutput("fill_level", 32'(lvlObs[0]), 32'(fillLvl[t]));
            if (t == 3) begin
                checkOutput("fill_q_tick4", 32'(qObs[0]), 32'h11);
                checkOutput("fill_qv_tick4", 32'(qvObs[0]), 32'h1);
            end
            if (t == 4) checkOutput("fill_q_tick5", 32'(qObs[0]), 32'h22);
        end

        for (int t = 0; t < 8; t++) begin
            feedMainTick(1'b0, 8'($urandom), (t % 2) == 0);
            if (t >= 3) begin
                checkOutput("bubble_level", 32'(lvlObs[0]), 32'd2);
                checkOutput("bubble_qv", 32'(qvObs[0]), ((t - 3) % 2) == 0 ? 32'd1 : 32'd0);
            end
        end

        for (int t = 0; t < 4; t++) feedMainTick(1'b0, 8'($urandom), 1'b1);
        checkOutput("full_level", 32'(lvlObs[0]), 32'd4);
        feedMainTick(1'b1, 8'hAA, 1'b1);
        checkOutput("flush_level", 32'(lvlObs[0]), 32'd0);
        checkOutput("flush_qv", 32'(qvObs[0]), 32'd0);
        for (int t = 0; t < 3; t++) feedMainTick(1'b0, 8'($urandom), 1'b0);
        checkOutput("flushed_q", 32'(qObs[0]), 32'hAA);
        checkOutput("flushed_qv", 32'(qvObs[0]), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom), 1'($urandom));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom));

        begin
            int guard = 0;
            while (!expClk(0) && guard < 20) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
                guard++;
            end
            checkOutput("clkout_high_before_reset", 32'(expClk(0)), 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b1);
        begin
            int edges = 0;
            for (int k = 0; k < NI; k++) firstRise[k] = -1;
            while (edges < 20 && (firstRise[0] < 0 || firstRise[1] < 0 || firstRise[2] < 0)) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
                edges++;
                for (int k = 0; k < NI; k++)
                    if (firstRise[k] < 0 && clkObs[k]) firstRise[k] = edges;
            end
            for (int k = 0; k < NI; k++)
                checkOutput($sformatf("first_rise_i%0d", k), 32'(firstRise[k]), 32'(divv[k]));
        end

        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom % 100) < 2, ($urandom % 100) < 8, ($urandom % 100) < 5,
                          8'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/dff_clkdiv_pipe.md
# dff_clkdiv_pipe

Parametrised successor to the single-bit clock-forwarding flop. The block divides `clk` by a programmable ratio, drives the divided clock on `clkout`, and advances a WIDTH-bit, DEPTH-stage register pipeline on each `clkout` rising event. All logic runs in the single `clk` domain, with `clkout` rises used as clock enables. It sits between a fast-clock source and slow-clock consumers in the cosimulation benches, which see `clkout` plus data aligned to it.

## Interface
- `WIDTH`, default 8: data width in bits, ≥1.
- `DEPTH`, default 4: number of pipeline stages, ≥1.
- `DIV`, default 2: `clkout` half-period in `clk` cycles, ≥1. The `clkout` period is 2·DIV cycles.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `hold` input 1: freezes the divider, `clkout` and the pipeline while high.
- `flush` input 1: clears all stage valid bits (synchronous).
- `d` input WIDTH: data sampled on each `clkout` rise.
- `d_valid` input 1: valid flag sampled together with `d`.
- `clkout` output 1: divided clock, registered.
- `tick` output 1: combinational; high on the `clk` cycle whose closing edge produces a `clkout` rise.
- `q` output WIDTH: data of the last stage (stage DEPTH-1), registered.
- `q_valid` output 1: valid bit of the last stage.
- `level` output $clog2(DEPTH+1): number of stages with their valid bit set, 0..DEPTH.

## Operation
- **Divider**
  - The counter `cnt` has range 0..DIV-1.
  - On each `clk` edge with `hold`=0: if `cnt`==DIV-1, then `cnt`←0 and `clkout`←~`clkout`; otherwise `cnt`←`cnt`+1.
- **Tick**
  - `tick` = (`cnt`==DIV-1) & ~`clkout` & ~`hold` & ~`reset`.
  - Falling `clkout` transitions have no effect on the pipeline.
- **Shift on tick**
  - stage[0] ← {`d`, `d_valid`}.
  - stage[i] ← stage[i-1] for i = 1..DEPTH-1.
  - The old stage[DEPTH-1] is discarded.
  - Data moves regardless of valid bits; invalid bubbles propagate.
- **DEPTH=1**
  - `q` ← `d` on each tick, the same behaviour as a single flop clocked by `clkout`.
- **Flush**
  - All valid bits are cleared on that edge. Data registers keep their values, or shift if `tick`=1.
  - If `flush` and `tick` coincide, the incoming `d_valid` is also discarded. After that edge every valid bit is 0, and `level`=0.
- **Hold**
  - `cnt`, `clkout`, data and valid bits are all frozen.
  - `flush` is still honoured during `hold`.
  - Releasing `hold` resumes counting from the frozen `cnt`.
- **Level**
  - `level` is registered and equals the popcount of the valid bits after each edge.
  - Tick changes: +1 if `d_valid` enters while stage[DEPTH-1] was invalid; −1 if the last stage was valid and `d_valid`=0; otherwise unchanged.
  - `level` never exceeds DEPTH.
- **Reset**
  - Reset is synchronous, has top priority, and is honoured even mid-period or during `hold`.
  - Reset values: `cnt`=0, `clkout`=0, every stage data=0, every valid=0, `q`=0, `q_valid`=0, `level`=0.
  - `tick` is forced to 0 while `reset`=1.

## Timing
- **First rise after reset:** with the first non-reset edge numbered E1, the first `clkout` rise occurs at edge E(DIV).
  - Subsequent rises occur every 2·DIV edges.
  - Falls occur DIV edges after each rise.
- **DIV=1:** `clkout` toggles on every edge. `tick` is high on every other cycle.
- **Latency:** a sample taken on tick k appears on `q`/`q_valid` immediately after tick k+DEPTH-1. That is DEPTH-1 further ticks, or (DEPTH-1)·2·DIV `clk` cycles.
- **Alignment:** `q` changes only on the same `clk` edge on which `clkout` rises. Between rises it is stable for 2·DIV cycles.
- **Effect timing:** `flush` and `hold` act on the edge at which they are sampled high. There are no extra pipeline delays.

## Test plan
1. **Reset values.** Hold `reset`=1 for 3 cycles with `d`=0xFF and `d_valid`=1 → `clkout`=0, `q`=0, `q_valid`=0, `level`=0, `tick` never high. Then release `reset` → first `clkout` rise at edge E(DIV).
2. **Divider sweep.** Run DIV=1, 2 and 3 for 12 rises each → `clkout` period 2, 4 and 6 cycles; 50% duty; exactly one `tick` per period, in the cycle before each rise.
3. **Latency and fill, DEPTH=4, DIV=2.** Feed `d`=0x11, 0x22, 0x33, 0x44, 0x55 with `d_valid`=1 on successive ticks → `q`=0x11 and `q_valid`=1 after the 4th tick; `q`=0x22 after the 5th. `level` counts 1, 2, 3, 4, 4.
4. **Bubbles.** Pattern `d_valid`=1, 0, 1, 0 → `q_valid` reproduces the same pattern DEPTH-1 ticks later; `level` stays at 2 once full.
5. **Flush coinciding with tick.** With the pipeline full (`level`=4), assert `flush` on a `tick` cycle with `d`=0xAA and `d_valid`=1 → `level`=0 and `q_valid`=0 on the following cycles; 0xAA still enters stage 0 but never shows `q_valid`=1.
6. **Hold and mid-period reset.** Assert `hold` for 5 cycles mid-period → `clkout`, `cnt` and `q` frozen; the period resumes with the remaining count. Then assert `reset` for 1 cycle while `clkout`=1 → all outputs at reset values on the next cycle, and the next rise comes DIV edges after reset deasserts.
